bounce_offset_ctrl: RTL
=======================

# bounce_offset_ctrl

Per-frame motion controller for the VGA pattern demo. It sits between the sync generator and the pixel-pattern logic. It detects the start of vertical sync in the pixel-clock domain and, once per frame, advances a pair of 10-bit scroll offsets that bounce between 0 and programmable maxima. The pattern stage adds `offset_x`/`offset_y` to `hpos`/`vpos`. The controller replaces clocking logic on `vsync` with a fully synchronous, single-clock update.

## Interface
- `X_MAX`, default 512: upper bound for `offset_x`. Legal range 1..1023.
- `Y_MAX`, default 256: upper bound for `offset_y`. Legal range 1..1023.
- `clk`  in  1  pixel clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `vsync`  in  1  vertical sync from the sync generator. Same clock domain. The frame event is the rising edge.
- `pause`  in  1  when 1, frame events are ignored and offsets hold.
- `speed_x`  in  3  pixels per frame for the X axis. 0 means hold.
- `speed_y`  in  3  pixels per frame for the Y axis. 0 means hold.
- `offset_x`  out  10  current X offset. Registered.
- `offset_y`  out  10  current Y offset. Registered.
- `dir_x`  out  1  X direction: 1 = increasing, 0 = decreasing.
- `dir_y`  out  1  Y direction: 1 = increasing, 0 = decreasing.
- `bounce_x`  out  1  one-cycle pulse when X hits a bound in the current update.
- `bounce_y`  out  1  one-cycle pulse when Y hits a bound in the current update.
- `update_done`  out  1  one-cycle pulse after both axes have been updated for a frame.

## Operation
- Edge detect: register `vsync_d <= vsync`. `tick = vsync & ~vsync_d`.
- FSM states:
  - WAIT: if `tick & ~pause`, go to UPD_X. Otherwise stay. A tick while paused is dropped; there is no deferred update.
  - UPD_X: update the X axis, then go to UPD_Y.
  - UPD_Y: update the Y axis, then go to DONE.
  - DONE: assert `update_done` for this cycle, then go to WAIT.
- `tick` is ignored in UPD_X, UPD_Y and DONE. It cannot legally recur within 3 cycles.
- Axis update, for axis A with offset `o`, step `s = speed_A` sampled in the A-update state, and bound `M`:
  - Arithmetic is done at 11 bits; no 10-bit wrap-around is permitted.
  - `s == 0`: `o`, `dir` and `bounce` are unchanged.
  - `dir == 1`: if `o + s >= M`, then `o <= M`, `dir <= 0`, pulse `bounce`. Otherwise `o <= o + s`.
  - `dir == 0`: if `o <= s`, then `o <= 0`, `dir <= 1`, pulse `bounce`. Otherwise `o <= o - s`.
  - Landing exactly on a bound counts as a hit: it clamps, flips direction and pulses.
- `bounce_x` can only be high during the cycle after UPD_X. `bounce_y` can only be high during the cycle after UPD_Y. Both are low at all other times.
- Reset values:
  - `offset_x = offset_y = 0`.
  - `dir_x = dir_y = 1`.
  - `bounce_x = bounce_y = update_done = 0`.
  - FSM in WAIT.
  - `vsync_d = 1`. This suppresses a spurious tick if `vsync` is already high when reset releases.
- Reset asserted mid-update (in UPD_X, UPD_Y or DONE) aborts the update. All state takes its reset values on the next edge, and no partial update survives.

## Timing
- Let T be the cycle where `vsync` is first sampled 1 (with `vsync_d` = 0). `tick` is combinational in T, so the FSM enters UPD_X at edge T+1.
- `offset_x`, `dir_x` and `bounce_x` change at edge T+2.
- `offset_y`, `dir_y` and `bounce_y` change at edge T+3.
- `update_done` is high during cycle T+3, i.e. while the FSM is in DONE.
- The FSM is back in WAIT at T+4. Throughput is one update per frame.
- All outputs are registered with no combinational path from inputs.
- Offsets change only during vsync, never during the active video area.

## Test plan
- Reset, then hold `vsync` high across reset release, with speeds 1/2 -> no update and no `update_done` until `vsync` falls and rises again.
- `speed_x=1`, `speed_y=2`, 3 vsync rising edges -> `offset_x` = 1,2,3 and `offset_y` = 2,4,6. `update_done` pulses exactly at T+3 after each edge. Offsets are stable outside those windows.
- `X_MAX=10`, `speed_x=3` from 0 -> `offset_x` sequence 3,6,9,10(`bounce_x`, `dir_x=0`),7,4,1,0(`bounce_x`, `dir_x=1`),3.
- `speed_y=0` across 5 frames -> `offset_y` and `dir_y` unchanged, no `bounce_y`. X still advances normally.
- `pause=1` across 3 vsync edges -> no state change and no `update_done`. Releasing `pause` between edges -> the next edge updates normally with no burst.
- `reset` asserted in the UPD_Y cycle -> next cycle shows all reset values and no `update_done`. A subsequent frame behaves as if starting fresh.

Source files
------------

// File: rtl/bounce_offset_ctrl_if.sv
// Sync-side and pattern-side signals of the per-frame scroll controller.
// The master drives vsync, pause and speeds; the slave returns offsets and status.
interface bounce_offset_ctrl_if;
    logic       vsync;
    logic       pause;
    logic [2:0] speed_x;
    logic [2:0] speed_y;
    logic [9:0] offset_x;
    logic [9:0] offset_y;
    logic       dir_x;
    logic       dir_y;
    logic       bounce_x;
    logic       bounce_y;
    logic       update_done;

    modport master (
        output vsync, pause, speed_x, speed_y,
        input  offset_x, offset_y, dir_x, dir_y, bounce_x, bounce_y, update_done
    );

    modport slave (
        input  vsync, pause, speed_x, speed_y,
        output offset_x, offset_y, dir_x, dir_y, bounce_x, bounce_y, update_done
    );
endinterface

// File: rtl/bounce_offset_ctrl.sv
// Once-per-frame bouncing scroll offsets for the VGA pattern demo, advanced on
// the rising edge of vsync. The whole design runs in the pixel-clock domain.
module bounce_offset_ctrl #(
    parameter int X_MAX = 512,
    parameter int Y_MAX = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    bounce_offset_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        UPD_X = 2'd1,
        UPD_Y = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   vsync_d_reg;
    logic   tick;
    logic   update_done_reg;

    // vsync_d resets high so a vsync already high at reset release is not a frame event
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_d_reg <= 1'b1;
        end else begin
            vsync_d_reg <= bus.vsync;
        end
    end

    assign tick = bus.vsync & ~vsync_d_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= WAIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT:    if (tick && !bus.pause) state_next = UPD_X;
            UPD_X:   state_next = UPD_Y;
            UPD_Y:   state_next = DONE;
            DONE:    state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    // Registered so the pulse coincides with the DONE state
    always_ff @(posedge clk) begin
        if (reset) begin
            update_done_reg <= 1'b0;
        end else begin
            update_done_reg <= (state_reg == UPD_Y);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic [10:0] BOUND     = (gi == 0) ? 11'(X_MAX) : 11'(Y_MAX);
            localparam state_t      UPD_STATE = (gi == 0) ? UPD_X : UPD_Y;

            logic [9:0]  offset_reg;
            logic [9:0]  offset_next;
            logic        dir_reg;
            logic        dir_next;
            logic        bounce_reg;
            logic        bounce_next;
            logic [2:0]  step;
            logic [10:0] step_wide;
            logic [10:0] sum_wide;
            logic        upd_en;

            assign step      = (gi == 0) ? bus.speed_x : bus.speed_y;
            assign upd_en    = (state_reg == UPD_STATE);
            assign step_wide = {8'd0, step};
            // 11-bit sum so offset + step can never wrap before the bound compare
            assign sum_wide  = {1'b0, offset_reg} + step_wide;

            always_comb begin
                offset_next = offset_reg;
                dir_next    = dir_reg;
                bounce_next = 1'b0;
                if (upd_en && (step != 3'd0)) begin
                    if (dir_reg) begin
                        if (sum_wide >= BOUND) begin
                            offset_next = BOUND[9:0];
                            dir_next    = 1'b0;
                            bounce_next = 1'b1;
                        end else begin
                            offset_next = sum_wide[9:0];
                        end
                    end else begin
                        if ({1'b0, offset_reg} <= step_wide) begin
                            offset_next = 10'd0;
                            dir_next    = 1'b1;
                            bounce_next = 1'b1;
                        end else begin
                            offset_next = offset_reg - {7'd0, step};
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    offset_reg <= 10'd0;
                    dir_reg    <= 1'b1;
                    bounce_reg <= 1'b0;
                end else begin
                    offset_reg <= offset_next;
                    dir_reg    <= dir_next;
                    bounce_reg <= bounce_next;
                end
            end
        end
    endgenerate

    assign bus.offset_x    = g_axis[0].offset_reg;
    assign bus.offset_y    = g_axis[1].offset_reg;
    assign bus.dir_x       = g_axis[0].dir_reg;
    assign bus.dir_y       = g_axis[1].dir_reg;
    assign bus.bounce_x    = g_axis[0].bounce_reg;
    assign bus.bounce_y    = g_axis[1].bounce_reg;
    assign bus.update_done = update_done_reg;

endmodule
